// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg
//   Shared types and helpers for the memory BIST engine.
//   - phase_e : march phase (all-zero, data=address, data=~address)
//   - state_e : controller FSM state
//   - pattern : expected memory contents for a phase/address pair,
//               computed at PAT_W bits so any ADDR_W/DATA_W <= PAT_W
//               can take the low bits it needs.
package mem_bist_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ERR_W_DEF  = 8;
    localparam int unsigned PAT_W      = 32;

    typedef enum logic [1:0] {
        PH_ZERO = 2'd0,
        PH_ADDR = 2'd1,
        PH_INV  = 2'd2
    } phase_e;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        CHECK,
        DONE
    } state_e;

    // Address is zero-extended before inversion, so the INV pattern has
    // its upper (DATA_W - ADDR_W) bits set.
    function automatic logic [PAT_W-1:0] pattern(input phase_e ph,
                                                 input logic [PAT_W-1:0] a);
        case (ph)
            PH_ZERO: return '0;
            PH_ADDR: return a;
            PH_INV:  return ~a;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/mem_bist_if.sv
// mem_bist_if
//   Memory-side bus between the BIST engine and a 1-cycle-latency
//   synchronous single-port memory.
//   - read     : read strobe, data_out valid the cycle after
//   - write    : write strobe, data_in stored at addr
//   - addr     : word address
//   - data_in  : write data (towards memory)
//   - data_out : read data (from memory)
//   Modports: master = BIST engine, slave = memory.
interface mem_bist_if
    import mem_bist_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (
        output read,
        output write,
        output addr,
        output data_in,
        input  data_out
    );

    modport slave (
        input  read,
        input  write,
        input  addr,
        input  data_in,
        output data_out
    );

endinterface

// File: rtl/mem_bist_errlog.sv
// mem_bist_errlog
//   Error bookkeeping for one BIST run.
//   - clk, rst         : clock, async active-high reset
//   - clr              : start of a new run, clears everything
//   - mismatch         : one compare failed this cycle
//   - addr, phase      : location of the compare
//   - err_count        : saturating mismatch count
//   - first_err_addr   : address of the first mismatch (0 if none)
//   - first_err_phase  : phase of the first mismatch (0 if none)
module mem_bist_errlog
    import mem_bist_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned ERR_W  = ERR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              mismatch,
    input  logic [ADDR_W-1:0] addr,
    input  phase_e            phase,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [1:0]        first_err_phase
);

    // Separate flag rather than err_count==0 so first-error capture does
    // not depend on the counter width.
    logic seen_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count       <= '0;
            first_err_addr  <= '0;
            first_err_phase <= '0;
            seen_q          <= 1'b0;
        end else if (clr) begin
            err_count       <= '0;
            first_err_addr  <= '0;
            first_err_phase <= '0;
            seen_q          <= 1'b0;
        end else if (mismatch) begin
            if (err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
            if (!seen_q) begin
                seen_q          <= 1'b1;
                first_err_addr  <= addr;
                first_err_phase <= phase;
            end
        end
    end

endmodule

// File: rtl/mem_bist.sv
// mem_bist
//   March-style BIST engine for a synchronous single-port memory.
//   Three phases (all-zero, data=address, data=~address), each a full
//   write sweep followed by a read/compare sweep (READ then CHECK per word).
//   - clk, rst         : clock shared with memory, async active-high reset
//   - start            : request a run, honoured only in IDLE or DONE
//   - busy             : run in progress
//   - done             : run finished, held until next start or reset
//   - pass             : done and no mismatches
//   - err_count        : saturating mismatch count
//   - first_err_addr   : address of first mismatch (0 if none)
//   - first_err_phase  : phase of first mismatch (0 if none)
//   - mem              : memory bus (master side), all outputs registered
module mem_bist
    import mem_bist_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ERR_W  = ERR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [1:0]        first_err_phase,
    mem_bist_if.master        mem
);

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              read_q,  read_d;
    logic              write_q, write_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              start_accept;
    logic              mismatch;
    logic [ADDR_W-1:0] addr_inc;

    function automatic logic [DATA_W-1:0] pat(input phase_e ph,
                                              input logic [ADDR_W-1:0] a);
        logic [PAT_W-1:0] w;
        w = pattern(ph, PAT_W'(a));
        return w[DATA_W-1:0];
    endfunction

    function automatic phase_e next_phase(input phase_e ph);
        case (ph)
            PH_ZERO: return PH_ADDR;
            PH_ADDR: return PH_INV;
            default: return PH_INV;
        endcase
    endfunction

    assign addr_inc = addr_q + 1'b1;

    // data_out holds the word read in the previous (READ) cycle.
    assign mismatch = (state_q == CHECK) && (mem.data_out != pat(phase_q, addr_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= PH_ZERO;
            addr_q  <= '0;
            data_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            read_q  <= read_d;
            write_q <= write_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Strobes are computed one cycle ahead so they leave registers and line
    // up with the state they belong to (write_q=1 throughout WRITE, read_q=1
    // only in READ).
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        addr_d       = addr_q;
        data_d       = data_q;
        read_d       = 1'b0;
        write_d      = 1'b0;
        busy_d       = busy_q;
        done_d       = done_q;
        start_accept = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_d      = WRITE;
                    phase_d      = PH_ZERO;
                    addr_d       = '0;
                    data_d       = pat(PH_ZERO, '0);
                    write_d      = 1'b1;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                end
            end
            WRITE: begin
                if (addr_q == '1) begin
                    addr_d  = '0;
                    read_d  = 1'b1;
                    state_d = READ;
                end else begin
                    addr_d  = addr_inc;
                    data_d  = pat(phase_q, addr_inc);
                    write_d = 1'b1;
                end
            end
            READ: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (addr_q != '1) begin
                    addr_d  = addr_inc;
                    read_d  = 1'b1;
                    state_d = READ;
                end else if (phase_q != PH_INV) begin
                    phase_d = next_phase(phase_q);
                    addr_d  = '0;
                    data_d  = pat(next_phase(phase_q), '0);
                    write_d = 1'b1;
                    state_d = WRITE;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mem_bist_errlog #(
        .ADDR_W (ADDR_W),
        .ERR_W  (ERR_W)
    ) u_errlog (
        .clk             (clk),
        .rst             (rst),
        .clr             (start_accept),
        .mismatch        (mismatch),
        .addr            (addr_q),
        .phase           (phase_q),
        .err_count       (err_count),
        .first_err_addr  (first_err_addr),
        .first_err_phase (first_err_phase)
    );

    assign mem.read    = read_q;
    assign mem.write   = write_q;
    assign mem.addr    = addr_q;
    assign mem.data_in = data_q;

    assign busy = busy_q;
    assign done = done_q;
    assign pass = done_q && (err_count == '0);

endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist
//   Directed bench for mem_bist. Two engines share clk/rst:
//   dut_a (ERR_W=8) with a selectable memory model (good / data_out[3]
//   stuck-at-0 / constant 8'hFF), dut_b (ERR_W=6) with a constant-8'hFF
//   memory. Protocol checks run every cycle on both buses.
module tb_mem_bist;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    logic       busy_a, done_a, pass_a;
    logic [7:0] err_a;
    logic [4:0] fea_a;
    logic [1:0] fep_a;

    logic       busy_b, done_b, pass_b;
    logic [5:0] err_b;
    logic [4:0] fea_b;
    logic [1:0] fep_b;

    int n_assert = 0;
    int n_fail   = 0;
    int mode_a   = 0;   // 0 good, 1 bit3 stuck-at-0, 2 constant FF
    int mode_b   = 2;
    int n;

    mem_bist_if #(.ADDR_W(5), .DATA_W(8)) bus_a ();
    mem_bist_if #(.ADDR_W(5), .DATA_W(8)) bus_b ();

    mem_bist #(.ADDR_W(5), .DATA_W(8), .ERR_W(8)) dut_a (
        .clk             (clk),
        .rst             (rst),
        .start           (start_a),
        .busy            (busy_a),
        .done            (done_a),
        .pass            (pass_a),
        .err_count       (err_a),
        .first_err_addr  (fea_a),
        .first_err_phase (fep_a),
        .mem             (bus_a)
    );

    mem_bist #(.ADDR_W(5), .DATA_W(8), .ERR_W(6)) dut_b (
        .clk             (clk),
        .rst             (rst),
        .start           (start_b),
        .busy            (busy_b),
        .done            (done_b),
        .pass            (pass_b),
        .err_count       (err_b),
        .first_err_addr  (fea_b),
        .first_err_phase (fep_b),
        .mem             (bus_b)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fault(input int m, input logic [7:0] d);
        if (m == 1) return d & 8'hF7;
        if (m == 2) return 8'hFF;
        return d;
    endfunction

    function automatic logic [7:0] exp_pat(input int ph, input logic [4:0] a);
        if (ph == 0) return 8'h00;
        if (ph == 1) return {3'b000, a};
        return ~{3'b000, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural 32x8 memories, 1-cycle read latency.
    logic [7:0] mem_a [32];
    logic [7:0] mem_b [32];

    always @(posedge clk) begin
        if (bus_a.write) mem_a[bus_a.addr] <= bus_a.data_in;
        if (bus_a.read)  bus_a.data_out    <= fault(mode_a, mem_a[bus_a.addr]);
    end

    always @(posedge clk) begin
        if (bus_b.write) mem_b[bus_b.addr] <= bus_b.data_in;
        if (bus_b.read)  bus_b.data_out    <= fault(mode_b, mem_b[bus_b.addr]);
    end

    // Protocol: read/write exclusive; write data follows the phase sequence,
    // phase inferred from the number of write beats since busy rose.
    int wcnt_a = 0;
    int wcnt_b = 0;

    always @(negedge clk) begin
        check("a_rw_excl", 32'(bus_a.read & bus_a.write), 32'd0);
        if (busy_a !== 1'b1) begin
            wcnt_a = 0;
        end else if (bus_a.write === 1'b1) begin
            check("a_wdata", 32'(bus_a.data_in), 32'(exp_pat(wcnt_a / 32, bus_a.addr)));
            wcnt_a++;
        end
    end

    always @(negedge clk) begin
        check("b_rw_excl", 32'(bus_b.read & bus_b.write), 32'd0);
        if (busy_b !== 1'b1) begin
            wcnt_b = 0;
        end else if (bus_b.write === 1'b1) begin
            check("b_wdata", 32'(bus_b.data_in), 32'(exp_pat(wcnt_b / 32, bus_b.addr)));
            wcnt_b++;
        end
    end

    // Returns at the falling edge just after the accepting rising edge.
    task automatic pulse(input logic a, input logic b);
        @(negedge clk);
        start_a = a;
        start_b = b;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Counts falling edges with busy_a high, bounded.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy_a === 1'b1 && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy",  32'(busy_a), 32'd0);
        check("rst_done",  32'(done_a), 32'd0);
        check("rst_pass",  32'(pass_a), 32'd0);
        check("rst_err",   32'(err_a),  32'd0);
        check("rst_fea",   32'(fea_a),  32'd0);
        check("rst_fep",   32'(fep_a),  32'd0);
        check("rst_read",  32'(bus_a.read),    32'd0);
        check("rst_write", 32'(bus_a.write),   32'd0);
        check("rst_addr",  32'(bus_a.addr),    32'd0);
        check("rst_din",   32'(bus_a.data_in), 32'd0);
        rst = 1'b0;

        // Run 1: good memory on A, constant-FF memory on B (ERR_W=6)
        mode_a = 0;
        mode_b = 2;
        pulse(1'b1, 1'b1);
        wait_idle(n);
        check("r1_cycles", 32'(n), 32'd288);
        check("r1_done",   32'(done_a), 32'd1);
        check("r1_pass",   32'(pass_a), 32'd1);
        check("r1_err",    32'(err_a),  32'd0);
        check("r1_fea",    32'(fea_a),  32'd0);
        check("r1_fep",    32'(fep_a),  32'd0);
        check("b_busy",    32'(busy_b), 32'd0);
        check("b_done",    32'(done_b), 32'd1);
        check("b_pass",    32'(pass_b), 32'd0);
        check("b_err_sat", 32'(err_b),  32'd63);
        check("b_fea",     32'(fea_b),  32'd0);
        check("b_fep",     32'(fep_b),  32'd0);

        // Run 2: data_out[3] stuck-at-0
        mode_a = 1;
        pulse(1'b1, 1'b0);
        wait_idle(n);
        check("r2_cycles", 32'(n), 32'd288);
        check("r2_done",   32'(done_a), 32'd1);
        check("r2_pass",   32'(pass_a), 32'd0);
        check("r2_err",    32'(err_a),  32'd32);
        check("r2_fea",    32'(fea_a),  32'd8);
        check("r2_fep",    32'(fep_a),  32'd1);

        // Run 3: restart from DONE clears the failing result
        mode_a = 0;
        pulse(1'b1, 1'b0);
        check("r3_done0",  32'(done_a), 32'd0);
        check("r3_busy1",  32'(busy_a), 32'd1);
        check("r3_pass0",  32'(pass_a), 32'd0);
        check("r3_err0",   32'(err_a),  32'd0);
        check("r3_fea0",   32'(fea_a),  32'd0);
        check("r3_fep0",   32'(fep_a),  32'd0);
        check("r3_write",  32'(bus_a.write),   32'd1);
        check("r3_read",   32'(bus_a.read),    32'd0);
        check("r3_addr",   32'(bus_a.addr),    32'd0);
        check("r3_din",    32'(bus_a.data_in), 32'd0);
        wait_idle(n);
        check("r3_cycles", 32'(n), 32'd288);
        check("r3_pass",   32'(pass_a), 32'd1);

        // Run 4: start pulses mid-run are ignored
        pulse(1'b1, 1'b0);
        n = 0;
        while (busy_a === 1'b1 && n < 1000) begin
            n++;
            start_a = (n == 10 || n == 200);
            @(negedge clk);
        end
        start_a = 1'b0;
        check("r4_cycles", 32'(n), 32'd288);
        check("r4_done",   32'(done_a), 32'd1);
        check("r4_pass",   32'(pass_a), 32'd1);

        // Run 5: async reset at cycle 100 of a failing run, then a clean run
        mode_a = 2;
        pulse(1'b1, 1'b0);
        repeat (99) @(negedge clk);
        check("r5_err_pre",  32'(err_a),  32'd32);
        check("r5_busy_pre", 32'(busy_a), 32'd1);
        rst = 1'b1;
        #1;
        check("r5_read",  32'(bus_a.read),  32'd0);
        check("r5_write", 32'(bus_a.write), 32'd0);
        check("r5_busy",  32'(busy_a), 32'd0);
        check("r5_done",  32'(done_a), 32'd0);
        check("r5_err",   32'(err_a),  32'd0);
        check("r5_pass",  32'(pass_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("r5_no_resume", 32'(busy_a), 32'd0);
        mode_a = 0;
        pulse(1'b1, 1'b0);
        wait_idle(n);
        check("r6_cycles", 32'(n), 32'd288);
        check("r6_done",   32'(done_a), 32'd1);
        check("r6_pass",   32'(pass_a), 32'd1);
        check("r6_err",    32'(err_a),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
